// File: rtl/jpeg_stream_packer_if.sv
// jpeg_stream_packer_if
// Groups the two streaming buses of the JPEG stream packer:
//   coder side  : in_data, in_valid, in_last  -> packer, in_hold  <- packer
//   buffer side : out_data, out_addr, out_valid <- packer, out_hold -> packer
// Modports:
//   slave  - the packer itself (sinks coder beats, sources buffer words)
//   master - the environment around it (coder + image buffer)
interface jpeg_stream_packer_if #(
    parameter int IN_BYTES  = 4,
    parameter int OUT_BYTES = 16,
    parameter int ADDR_W    = 20
);
    logic [8*IN_BYTES-1:0]  in_data;
    logic                   in_valid;
    logic                   in_last;
    logic                   in_hold;
    logic [8*OUT_BYTES-1:0] out_data;
    logic [ADDR_W-1:0]      out_addr;
    logic                   out_valid;
    logic                   out_hold;

    modport slave (
        input  in_data, in_valid, in_last, out_hold,
        output in_hold, out_data, out_addr, out_valid
    );

    modport master (
        output in_data, in_valid, in_last, out_hold,
        input  in_hold, out_data, out_addr, out_valid
    );
endinterface

// File: rtl/jpeg_stream_packer.sv
// jpeg_stream_packer
// Capture controller and width packer between the JPEG entropy-coder stream
// and the image buffer. It arms on request, starts capturing on frame start,
// packs IN_BYTES-wide coder beats into OUT_BYTES-wide words tagged with their
// byte address, and reports final size, completion and overflow.
// Ports:
//   clk               single clock
//   reset             synchronous, active-high
//   start_capture_in  arm request pulse (honoured in IDLE and DONE)
//   abort_in          abandon capture, back to IDLE next cycle
//   frame_start_in    frame start pulse, moves ARMED to CAPTURE
//   byte_swap_in      1: in_data MSB byte is the first stream byte
//   bus               coder/buffer streams (slave modport)
//   image_valid_out   capture complete
//   image_size_out    bytes accepted (unpadded), registered on DONE entry
//   overflow_out      sticky: a beat was dropped because the buffer is full
//   busy_out          state is ARMED, CAPTURE or FLUSH
module jpeg_stream_packer #(
    parameter int IN_BYTES  = 4,
    parameter int OUT_BYTES = 16,
    parameter int ADDR_W    = 20,
    parameter int BUF_BYTES = 65536
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_capture_in,
    input  logic              abort_in,
    input  logic              frame_start_in,
    input  logic              byte_swap_in,
    jpeg_stream_packer_if.slave bus,
    output logic              image_valid_out,
    output logic [ADDR_W-1:0] image_size_out,
    output logic              overflow_out,
    output logic              busy_out
);

    localparam int IN_W  = 8 * IN_BYTES;
    localparam int OUT_W = 8 * OUT_BYTES;
    localparam int SLOTS = OUT_BYTES / IN_BYTES;

    localparam logic [ADDR_W-1:0] OFF_MASK      = ADDR_W'(OUT_BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_SLOT_OFF = ADDR_W'(OUT_BYTES - IN_BYTES);
    localparam logic [ADDR_W:0]   BUF_LIMIT     = (ADDR_W + 1)'(BUF_BYTES);
    localparam logic [ADDR_W:0]   IN_STEP       = (ADDR_W + 1)'(IN_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  size_q;
    logic [OUT_W-1:0]   acc_q;
    logic               swap_q;
    logic [OUT_W-1:0]   out_data_q;
    logic [ADDR_W-1:0]  out_addr_q;
    logic               out_valid_q;
    logic               image_valid_q;
    logic [ADDR_W-1:0]  image_size_q;
    logic               overflow_q;
    logic               busy_q;

    logic               in_hold_c;
    logic               beat_accept;
    logic               beat_drop;
    logic               word_done;
    logic [ADDR_W-1:0]  lane_off;
    logic [ADDR_W-1:0]  word_base;
    logic [IN_W-1:0]    beat_ordered;
    logic [OUT_W-1:0]   acc_merged;

    // Back-pressure: hold the coder while waiting for a frame, while draining,
    // and while a finished word is stuck at the buffer. IDLE/DONE never hold
    // so a coder running outside a capture cannot deadlock.
    assign in_hold_c = (state_q == ST_ARMED) ||
                       (state_q == ST_FLUSH) ||
                       ((state_q == ST_CAPTURE) && out_valid_q && bus.out_hold);

    assign beat_accept = (state_q == ST_CAPTURE) && bus.in_valid && !in_hold_c;

    // Once overflow is flagged the size is frozen, so every later beat of the
    // frame is dropped as well.
    assign beat_drop = overflow_q || (({1'b0, size_q} + IN_STEP) > BUF_LIMIT);

    assign lane_off  = size_q & OFF_MASK;
    assign word_base = size_q & ~OFF_MASK;

    // A word goes out when this beat fills its top slot or when the frame ends
    // with the word partial; both together still produce a single word.
    assign word_done = (lane_off == LAST_SLOT_OFF) || bus.in_last;

    // Put the beat into stream order: byte j of beat_ordered is the j-th
    // stream byte. Uses the swap setting captured at frame start.
    always_comb begin
        beat_ordered = '0;
        for (int j = 0; j < IN_BYTES; j++) begin
            if (swap_q) begin
                beat_ordered[8*j +: 8] = bus.in_data[8*(IN_BYTES-1-j) +: 8];
            end else begin
                beat_ordered[8*j +: 8] = bus.in_data[8*j +: 8];
            end
        end
    end

    // Drop the ordered beat into the slot addressed by the current byte
    // offset. The accumulator is zero above the fill point, so a partial word
    // comes out with zero padding for free.
    always_comb begin
        acc_merged = acc_q;
        for (int s = 0; s < SLOTS; s++) begin
            if (lane_off == ADDR_W'(s * IN_BYTES)) begin
                acc_merged[s*IN_W +: IN_W] = beat_ordered;
            end
        end
    end

    // Capture FSM with all outputs registered. abort_in beats every other
    // event; otherwise a taken word drops out_valid unless a new word is
    // issued in the same cycle (the later assignment wins).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            size_q        <= '0;
            acc_q         <= '0;
            swap_q        <= 1'b0;
            out_data_q    <= '0;
            out_addr_q    <= '0;
            out_valid_q   <= 1'b0;
            image_valid_q <= 1'b0;
            image_size_q  <= '0;
            overflow_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else if (abort_in) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            if (out_valid_q && !bus.out_hold) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_capture_in) begin
                        state_q       <= ST_ARMED;
                        size_q        <= '0;
                        acc_q         <= '0;
                        image_valid_q <= 1'b0;
                        overflow_q    <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end

                ST_ARMED: begin
                    if (frame_start_in) begin
                        state_q <= ST_CAPTURE;
                        swap_q  <= byte_swap_in;
                    end
                end

                ST_CAPTURE: begin
                    if (beat_accept) begin
                        if (beat_drop) begin
                            overflow_q <= 1'b1;
                        end else begin
                            size_q <= size_q + ADDR_W'(IN_BYTES);
                            if (word_done) begin
                                out_data_q  <= acc_merged;
                                out_addr_q  <= word_base;
                                out_valid_q <= 1'b1;
                                acc_q       <= '0;
                            end else begin
                                acc_q <= acc_merged;
                            end
                        end
                        if (bus.in_last) begin
                            state_q <= ST_FLUSH;
                        end
                    end
                end

                ST_FLUSH: begin
                    if (!out_valid_q || !bus.out_hold) begin
                        state_q       <= ST_DONE;
                        image_valid_q <= 1'b1;
                        image_size_q  <= size_q;
                        busy_q        <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_hold    = in_hold_c;
    assign bus.out_data   = out_data_q;
    assign bus.out_addr   = out_addr_q;
    assign bus.out_valid  = out_valid_q;
    assign image_valid_out = image_valid_q;
    assign image_size_out  = image_size_q;
    assign overflow_out    = overflow_q;
    assign busy_out        = busy_q;

endmodule

// File: tb/tb_jpeg_stream_packer.sv
// tb_jpeg_stream_packer
// Self-checking bench for jpeg_stream_packer (IN=4, OUT=16, buffer of 32
// bytes). Directed frames come from a table of expected results; corner cases
// (hold, abort, idle behaviour) are hand-written; random frames are compared
// against a byte-stream reference model.
module tb_jpeg_stream_packer;

    localparam int IN_BYTES  = 4;
    localparam int OUT_BYTES = 16;
    localparam int ADDR_W    = 20;
    localparam int BUF_BYTES = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_capture_in;
    logic              abort_in;
    logic              frame_start_in;
    logic              byte_swap_in;
    logic              image_valid_out;
    logic [ADDR_W-1:0] image_size_out;
    logic              overflow_out;
    logic              busy_out;

    jpeg_stream_packer_if #(
        .IN_BYTES (IN_BYTES),
        .OUT_BYTES(OUT_BYTES),
        .ADDR_W   (ADDR_W)
    ) bus ();

    jpeg_stream_packer #(
        .IN_BYTES (IN_BYTES),
        .OUT_BYTES(OUT_BYTES),
        .ADDR_W   (ADDR_W),
        .BUF_BYTES(BUF_BYTES)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_capture_in(start_capture_in),
        .abort_in        (abort_in),
        .frame_start_in  (frame_start_in),
        .byte_swap_in    (byte_swap_in),
        .bus             (bus),
        .image_valid_out (image_valid_out),
        .image_size_out  (image_size_out),
        .overflow_out    (overflow_out),
        .busy_out        (busy_out)
    );

    typedef struct {
        int           nBeats;
        bit           swap;
        int           expSize;
        int           expWords;
        bit           expOvf;
        logic [127:0] expFirst;
        logic [127:0] expLast;
    } vec_t;

    int            checkCount = 0;
    int            passCount  = 0;
    int            holdMode   = 0;
    logic [31:0]   sentBeats[$];
    logic [127:0]  gotData[$];
    logic [ADDR_W-1:0] gotAddr[$];
    vec_t          vecs[5];

    localparam logic [127:0] W0_SWAP1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] W1_SWAP1 = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
    localparam logic [127:0] W0_SWAP0 = 128'h0C0D0E0F_08090A0B_04050607_00010203;
    localparam logic [127:0] W1_P5    = 128'h00000000_00000000_00000000_10111213;
    localparam logic [127:0] W_ONE    = 128'h00000000_00000000_00000000_00010203;

    initial forever #5 clk = ~clk;

    // Buffer back-pressure: 0 = never, 1 = always, 2 = random.
    initial begin
        bus.out_hold = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (holdMode)
                0:       bus.out_hold = 1'b0;
                1:       bus.out_hold = 1'b1;
                default: bus.out_hold = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    // Record every word the buffer takes (valid and not held at the edge).
    initial forever begin
        @(negedge clk);
        if (bus.out_valid === 1'b1 && bus.out_hold === 1'b0) begin
            gotData.push_back(bus.out_data);
            gotAddr.push_back(bus.out_addr);
        end
    end

    function automatic logic [31:0] incBeat(input int b);
        logic [7:0] k;
        k = 8'(4 * b);
        return {k, k + 8'd1, k + 8'd2, k + 8'd3};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearCapture();
        sentBeats.delete();
        gotData.delete();
        gotAddr.delete();
    endtask

    // Arm, then start a frame; byte_swap_in is flipped afterwards to show
    // the packer keeps the value seen at frame start.
    task automatic armAndStart(input bit swap);
        byte_swap_in     = swap;
        start_capture_in = 1'b1;
        nextCycle();
        start_capture_in = 1'b0;
        frame_start_in   = 1'b1;
        @(negedge clk);
        checkOutput("armed_busy", busy_out, 1'b1);
        checkOutput("armed_in_hold", bus.in_hold, 1'b1);
        @(posedge clk);
        #1;
        frame_start_in = 1'b0;
        byte_swap_in   = ~swap;
    endtask

    task automatic sendBeat();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.in_hold && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("beat_accept", bus.in_hold, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic sendOne(input logic [31:0] beat, input bit last);
        bus.in_data  = beat;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        sendBeat();
        sentBeats.push_back(beat);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        @(negedge clk);
        while (!image_valid_out && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("image_valid", image_valid_out, 1'b1);
    endtask

    // Run one whole frame; startAt >= 0 repeats a start request during that beat.
    task automatic applyStimulus(input int nBeats, input bit swap, input bit randomData,
                                 input bit gaps, input int startAt);
        logic [31:0] beat;
        clearCapture();
        armAndStart(swap);
        for (int b = 0; b < nBeats; b++) begin
            beat = randomData ? 32'($urandom) : incBeat(b);
            if (gaps && $urandom_range(0, 3) == 0) begin
                nextCycle();
            end
            start_capture_in = (b == startAt);
            sendOne(beat, b == nBeats - 1);
            start_capture_in = 1'b0;
        end
        waitDone();
    endtask

    // Reference model: build the accepted byte stream, cut it into words.
    task automatic checkFrame(input bit swap);
        logic [7:0]   stream[$];
        logic [31:0]  b;
        logic [127:0] w;
        int           total;
        bit           ovf;
        int           nWords;
        total = 0;
        ovf   = 1'b0;
        foreach (sentBeats[i]) begin
            b = sentBeats[i];
            if (ovf || total + IN_BYTES > BUF_BYTES) begin
                ovf = 1'b1;
            end else begin
                for (int j = 0; j < IN_BYTES; j++) begin
                    stream.push_back(swap ? b[8*(IN_BYTES-1-j) +: 8] : b[8*j +: 8]);
                end
                total += IN_BYTES;
            end
        end
        nWords = ovf ? total / OUT_BYTES : (total + OUT_BYTES - 1) / OUT_BYTES;
        checkOutput("word_count", gotData.size(), nWords);
        for (int k = 0; k < nWords && k < gotData.size(); k++) begin
            w = '0;
            for (int i = 0; i < OUT_BYTES; i++) begin
                if (k * OUT_BYTES + i < total) w[8*i +: 8] = stream[k * OUT_BYTES + i];
            end
            checkOutput($sformatf("word%0d_data", k), gotData[k], w);
            checkOutput($sformatf("word%0d_addr", k), gotAddr[k], k * OUT_BYTES);
        end
        checkOutput("image_size", image_size_out, total);
        checkOutput("overflow", overflow_out, ovf);
        checkOutput("done_busy", busy_out, 1'b0);
    endtask

    initial begin
        vecs[0] = '{8,  1'b1, 32, 2, 1'b0, W0_SWAP1, W1_SWAP1};
        vecs[1] = '{5,  1'b0, 20, 2, 1'b0, W0_SWAP0, W1_P5};
        vecs[2] = '{10, 1'b1, 32, 2, 1'b1, W0_SWAP1, W1_SWAP1};
        vecs[3] = '{4,  1'b1, 16, 1, 1'b0, W0_SWAP1, W0_SWAP1};
        vecs[4] = '{1,  1'b0, 4,  1, 1'b0, W_ONE,    W_ONE};

        reset            = 1'b1;
        start_capture_in = 1'b0;
        abort_in         = 1'b0;
        frame_start_in   = 1'b0;
        byte_swap_in     = 1'b0;
        bus.in_data      = '0;
        bus.in_valid     = 1'b0;
        bus.in_last      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", bus.out_valid, 1'b0);
        checkOutput("rst_image_valid", image_valid_out, 1'b0);
        checkOutput("rst_overflow", overflow_out, 1'b0);
        checkOutput("rst_busy", busy_out, 1'b0);
        checkOutput("rst_out_data", bus.out_data, 128'h0);
        checkOutput("rst_out_addr", bus.out_addr, 0);
        checkOutput("rst_image_size", image_size_out, 0);

        // IDLE: frame start ignored, beats discarded without back-pressure.
        @(posedge clk);
        #1;
        frame_start_in = 1'b1;
        nextCycle();
        frame_start_in = 1'b0;
        bus.in_data    = 32'hDEADBEEF;
        bus.in_valid   = 1'b1;
        @(negedge clk);
        checkOutput("idle_busy", busy_out, 1'b0);
        checkOutput("idle_in_hold", bus.in_hold, 1'b0);
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("idle_out_valid", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;

        // Directed frames from the table.
        holdMode = 0;
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].nBeats, vecs[v].swap, 1'b0, 1'b0, -1);
            checkOutput($sformatf("vec%0d_size", v), image_size_out, vecs[v].expSize);
            checkOutput($sformatf("vec%0d_words", v), gotData.size(), vecs[v].expWords);
            checkOutput($sformatf("vec%0d_ovf", v), overflow_out, vecs[v].expOvf);
            if (gotData.size() > 0) begin
                checkOutput($sformatf("vec%0d_first", v), gotData[0], vecs[v].expFirst);
                checkOutput($sformatf("vec%0d_last", v), gotData[gotData.size()-1], vecs[v].expLast);
            end
            checkFrame(vecs[v].swap);
        end

        // DONE: stray beats are discarded without back-pressure.
        bus.in_valid = 1'b1;
        @(negedge clk);
        checkOutput("done_in_hold", bus.in_hold, 1'b0);
        repeat (2) nextCycle();
        @(negedge clk);
        checkOutput("done_out_valid", bus.out_valid, 1'b0);
        checkOutput("done_still_valid", image_valid_out, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;

        // Buffer stalls on the first word: coder held, word stable, nothing lost.
        holdMode = 1;
        nextCycle();
        clearCapture();
        armAndStart(1'b1);
        for (int b = 0; b < 4; b++) sendOne(incBeat(b), 1'b0);
        bus.in_data  = incBeat(4);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("hold_out_valid", bus.out_valid, 1'b1);
            checkOutput("hold_in_hold", bus.in_hold, 1'b1);
            checkOutput("hold_out_data", bus.out_data, W0_SWAP1);
            checkOutput("hold_out_addr", bus.out_addr, 0);
        end
        holdMode = 0;
        for (int b = 4; b < 8; b++) sendOne(incBeat(b), b == 7);
        waitDone();
        checkOutput("hold_size", image_size_out, 32);
        checkFrame(1'b1);

        // Abort with a word on the bus and a partial word in the packer.
        clearCapture();
        armAndStart(1'b1);
        for (int b = 0; b < 4; b++) sendOne(incBeat(b), 1'b0);
        bus.in_data  = incBeat(4);
        bus.in_valid = 1'b1;
        abort_in     = 1'b1;
        @(negedge clk);
        checkOutput("pre_abort_out_valid", bus.out_valid, 1'b1);
        @(posedge clk);
        #1;
        abort_in     = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("abort_out_valid", bus.out_valid, 1'b0);
        checkOutput("abort_busy", busy_out, 1'b0);
        checkOutput("abort_in_hold", bus.in_hold, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(4, 1'b1, 1'b0, 1'b0, -1);
        if (gotData.size() > 0) checkOutput("post_abort_word", gotData[0], W0_SWAP1);
        checkFrame(1'b1);

        // Start request mid-capture must be ignored.
        applyStimulus(6, 1'b0, 1'b0, 1'b0, 2);
        checkFrame(1'b0);

        // Random frames with random stalls, gaps and stray start requests.
        holdMode = 2;
        for (int f = 0; f < 25; f++) begin
            int n;
            bit sw;
            int sa;
            n  = $urandom_range(1, 10);
            sw = 1'($urandom_range(0, 1));
            sa = -1;
            if ($urandom_range(0, 3) == 0) sa = $urandom_range(0, n - 1);
            applyStimulus(n, sw, 1'b1, 1'b1, sa);
            checkFrame(sw);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
